// File: rtl/ble_tx_pkg.sv
// Shared definitions for the BLE transmit path.
//   ser_state_t        : serializer FSM states
//   BLE_WHITEN_TAP/LEN : whitening LFSR x^7+x^4+1 geometry
//   BLE_MEM_RD_LATENCY : default packet-RAM read latency (edges)
//   whiten_seed()      : LFSR seed for a channel index
package ble_tx_pkg;

  localparam int unsigned BLE_WHITEN_TAP     = 4;
  localparam int unsigned BLE_WHITEN_LEN     = 7;
  localparam int unsigned BLE_MEM_RD_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ser_state_t;

  // Position 0 is forced to 1; channel MSB lands in position 1, LSB in position 6.
  function automatic logic [BLE_WHITEN_LEN-1:0] whiten_seed(input logic [5:0] channel);
    logic [BLE_WHITEN_LEN-1:0] seed;
    seed[0] = 1'b1;
    for (int i = 1; i < 7; i++) begin
      seed[i] = channel[6-i];
    end
    return seed;
  endfunction

endpackage

// File: rtl/ble_whiten_lfsr.sv
// BLE data-whitening LFSR (x^7 + x^4 + 1), positions 0..6, output from position 6.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (LFSR cleared to 0)
//   i_seed         : load seed derived from i_channel (has priority over i_advance)
//   i_channel      : BLE channel index used for the seed
//   i_advance      : step the LFSR once
//   o_out          : current whitening bit (position 6)
module ble_whiten_lfsr
  import ble_tx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_seed,
  input  logic [5:0] i_channel,
  input  logic       i_advance,
  output logic       o_out
);

  logic [BLE_WHITEN_LEN-1:0] r_lfsr;
  logic [BLE_WHITEN_LEN-1:0] w_lfsr_step;

  // Rotate up by one (out feeds position 0), then fold out into the tap.
  always_comb begin
    w_lfsr_step = {r_lfsr[BLE_WHITEN_LEN-2:0], r_lfsr[BLE_WHITEN_LEN-1]};
    w_lfsr_step[BLE_WHITEN_TAP] = r_lfsr[BLE_WHITEN_TAP-1] ^ r_lfsr[BLE_WHITEN_LEN-1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= '0;
    end else if (i_seed) begin
      r_lfsr <= whiten_seed(i_channel);
    end else if (i_advance) begin
      r_lfsr <= w_lfsr_step;
    end
  end

  assign o_out = r_lfsr[BLE_WHITEN_LEN-1];

endmodule

// File: rtl/ble_packet_serializer.sv
// Reads a packet from the packet RAM and streams it LSB-first, one bit per BitTick,
// with optional BLE whitening starting at a programmable byte index.
// Ports:
//   Clock, Reset_n         : clock, asynchronous active-low reset
//   Start, Length          : request (IDLE only) and byte count from address 0
//   WhitenEn, WhitenFrom   : whitening enable and first whitened byte index
//   Channel                : LFSR seed source
//   BitTick                : symbol strobe (>= 4 cycles apart)
//   MemAddress, MemClockEn : RAM read port (one-cycle ClockEn per read)
//   MemQ                   : RAM read data, valid MEM_RD_LATENCY edges after the read
//   BitOut, BitValid       : current output bit and its qualifier
//   Busy, Done             : activity flag and one-cycle completion pulse
module ble_packet_serializer
  import ble_tx_pkg::*;
#(
  parameter int unsigned MEM_RD_LATENCY = BLE_MEM_RD_LATENCY
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [7:0] Length,
  input  logic       WhitenEn,
  input  logic [7:0] WhitenFrom,
  input  logic [5:0] Channel,
  input  logic       BitTick,
  output logic [7:0] MemAddress,
  output logic       MemClockEn,
  input  logic [7:0] MemQ,
  output logic       BitOut,
  output logic       BitValid,
  output logic       Busy,
  output logic       Done
);

  ser_state_t r_state;
  logic [7:0] r_len;
  logic       r_whiten_en;
  logic [7:0] r_whiten_from;
  logic [7:0] r_byte_idx;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shreg;
  logic [7:0] r_hold;
  logic [7:0] r_mem_addr;
  logic       r_mem_ce;
  logic       r_bit_valid;
  logic       r_busy;
  logic       r_done;

  // r_rd_pipe[k] is set k edges after a read was sampled by the RAM.
  logic [MEM_RD_LATENCY:1] r_rd_pipe;

  logic w_q_valid;
  logic w_whiten_act;
  logic w_last_byte;
  logic w_prefetch_more;
  logic w_lfsr_seed;
  logic w_lfsr_adv;
  logic w_lfsr_out;

  assign w_q_valid       = r_rd_pipe[MEM_RD_LATENCY];
  assign w_whiten_act    = r_whiten_en && (r_byte_idx >= r_whiten_from);
  assign w_last_byte     = (r_byte_idx == (r_len - 8'd1));
  // Another byte exists beyond the one about to be loaded from the holding register.
  assign w_prefetch_more = ({1'b0, r_byte_idx} + 9'd2) < {1'b0, r_len};
  assign w_lfsr_seed     = (r_state == IDLE) && Start;
  assign w_lfsr_adv      = (r_state == SHIFT) && BitTick && w_whiten_act;

  ble_whiten_lfsr u_lfsr (
    .i_clk     (Clock),
    .i_rst_n   (Reset_n),
    .i_seed    (w_lfsr_seed),
    .i_channel (Channel),
    .i_advance (w_lfsr_adv),
    .o_out     (w_lfsr_out)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd_pipe <= '0;
    end else begin
      r_rd_pipe[1] <= r_mem_ce;
      for (int i = 2; i <= int'(MEM_RD_LATENCY); i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_whiten_en   <= 1'b0;
      r_whiten_from <= '0;
      r_byte_idx    <= '0;
      r_bit_cnt     <= '0;
      r_shreg       <= '0;
      r_hold        <= '0;
      r_mem_addr    <= '0;
      r_mem_ce      <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_mem_ce <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (Start) begin
            r_len         <= Length;
            r_whiten_en   <= WhitenEn;
            r_whiten_from <= WhitenFrom;
            r_byte_idx    <= '0;
            r_bit_cnt     <= '0;
            r_busy        <= 1'b1;
            if (Length == 8'd0) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_mem_ce   <= 1'b1;
              r_mem_addr <= 8'd0;
              r_state    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (w_q_valid) begin
            r_shreg     <= MemQ;
            r_bit_valid <= 1'b1;
            r_byte_idx  <= '0;
            r_bit_cnt   <= '0;
            r_state     <= SHIFT;
            if (r_len > 8'd1) begin
              r_mem_ce   <= 1'b1;
              r_mem_addr <= 8'd1;
            end
          end
        end
        SHIFT: begin
          if (w_q_valid) begin
            r_hold <= MemQ;
          end
          if (BitTick) begin
            if (r_bit_cnt == 3'd7) begin
              if (w_last_byte) begin
                r_bit_valid <= 1'b0;
                r_done      <= 1'b1;
                r_state     <= DONE;
              end else begin
                r_shreg    <= r_hold;
                r_byte_idx <= r_byte_idx + 8'd1;
                r_bit_cnt  <= '0;
                if (w_prefetch_more) begin
                  r_mem_ce   <= 1'b1;
                  r_mem_addr <= r_byte_idx + 8'd2;
                end
              end
            end else begin
              r_shreg   <= {1'b0, r_shreg[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MemAddress = r_mem_addr;
  assign MemClockEn = r_mem_ce;
  assign BitValid   = r_bit_valid;
  assign Busy       = r_busy;
  assign Done       = r_done;
  // Pure function of registers, so it only moves on edges that consume a tick.
  assign BitOut     = r_bit_valid & (r_shreg[0] ^ (w_whiten_act & w_lfsr_out));

endmodule

// File: tb/tb_ble_packet_serializer.sv
module tb_ble_packet_serializer;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] Length = '0;
  logic       WhitenEn = 1'b0;
  logic [7:0] WhitenFrom = '0;
  logic [5:0] Channel = '0;
  logic       BitTick = 1'b0;
  logic [7:0] MemAddress;
  logic       MemClockEn;
  logic [7:0] MemQ;
  logic       BitOut;
  logic       BitValid;
  logic       Busy;
  logic       Done;

  ble_packet_serializer #(.MEM_RD_LATENCY(2)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Length     (Length),
    .WhitenEn   (WhitenEn),
    .WhitenFrom (WhitenFrom),
    .Channel    (Channel),
    .BitTick    (BitTick),
    .MemAddress (MemAddress),
    .MemClockEn (MemClockEn),
    .MemQ       (MemQ),
    .BitOut     (BitOut),
    .BitValid   (BitValid),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clock = ~Clock;

  // Packet RAM: address sampled on edge 1, data on MemQ after edge 2.
  logic [7:0] mem [256];
  logic [7:0] ram_stage;
  always @(posedge Clock) begin
    if (MemClockEn) ram_stage <= mem[MemAddress];
    MemQ <= ram_stage;
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues filled by the stimulus, drained by the monitor.
  typedef struct {int cyc; int reads;} done_t;
  bit    exp_bits[$];
  done_t exp_done[$];

  // Reference model: bit list straight from the whitening rules.
  task automatic push_expected(input int len, input bit wen, input int wfrom, input int ch);
    int p[7];
    int np[7];
    int out;
    p[0] = 1;
    for (int i = 1; i < 7; i++) p[i] = (ch >> (6 - i)) & 1;
    for (int b = 0; b < len; b++) begin
      for (int k = 0; k < 8; k++) begin
        int d;
        d = (mem[b] >> k) & 1;
        if (wen && b >= wfrom) begin
          out = p[6];
          d = d ^ out;
          np[0] = out;
          for (int i = 1; i < 7; i++) np[i] = p[i-1];
          np[4] = p[3] ^ out;
          p = np;
        end
        exp_bits.push_back(d[0]);
      end
    end
  endtask

  // Monitor
  bit m_pv = 0, m_pt = 0, m_pb = 0, m_after_done = 0;
  int m_ce_cnt = 0;
  always @(negedge Clock) begin
    if (!Reset_n) begin
      m_pv = 0; m_pt = 0; m_pb = 0; m_after_done = 0; m_ce_cnt = 0;
    end else begin
      if (m_after_done) begin
        check("busy_after_done", Busy, 0);
        m_after_done = 0;
      end
      if (MemClockEn) begin
        check("mem_address", MemAddress, m_ce_cnt);
        m_ce_cnt++;
      end
      if (BitValid && (!m_pv || m_pt)) begin
        if (exp_bits.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          check("bit_out", BitOut, exp_bits.pop_front());
          check("busy_during_bits", Busy, 1);
        end
      end else if (BitValid && m_pv) begin
        check("bit_stable", BitOut, m_pb);
      end
      if (m_pv && m_pt && !BitValid) begin
        check("done_after_last_tick", Done, 1);
        check("bits_left_at_end", exp_bits.size(), 0);
      end
      if (Done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          done_t d;
          d = exp_done.pop_front();
          if (d.cyc >= 0) check("done_cycle", cyc, d.cyc);
          check("reads_per_packet", m_ce_cnt, d.reads);
          check("done_bitvalid", BitValid, 0);
        end
        m_ce_cnt = 0;
        m_after_done = 1;
      end
      m_pv = BitValid; m_pt = BitTick; m_pb = BitOut;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_address"}, MemAddress, 0);
    check({tag, "_mem_clock_en"}, MemClockEn, 0);
    check({tag, "_bit_out"}, BitOut, 0);
    check({tag, "_bit_valid"}, BitValid, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
  endtask

  task automatic tick_clk();
    @(posedge Clock); #1;
  endtask

  task automatic send_packet(input int len, input bit wen, input int wfrom, input int ch,
                             input int sp_min, input int sp_max, input bit early_tick,
                             input bit busy_start, input int reset_ticks);
    done_t d;
    int    waited;
    push_expected(len, wen, wfrom, ch);
    tick_clk();
    Start = 1; Length = 8'(len); WhitenEn = wen; WhitenFrom = 8'(wfrom); Channel = 6'(ch);
    d.cyc = (len == 0) ? cyc + 1 : -1;
    d.reads = len;
    exp_done.push_back(d);
    tick_clk();
    Start = 0;
    // Inputs wander while busy; they must not matter.
    Length = 8'($urandom); WhitenEn = 1'($urandom); WhitenFrom = 8'($urandom);
    Channel = 6'($urandom);
    if (len > 0) begin
      if (early_tick) begin
        BitTick = 1; tick_clk(); BitTick = 0;
      end
      waited = 0;
      while (!BitValid && waited < 20) begin
        tick_clk(); waited++;
      end
      if (!BitValid) check("bitvalid_timeout", 0, 1);
      for (int t = 0; t < 8 * len; t++) begin
        int sp;
        sp = $urandom_range(sp_max, sp_min);
        if (busy_start && t == 5) begin
          Start = 1; Length = 8'(len + 3); tick_clk(); Start = 0; sp--;
        end
        repeat (sp - 1) tick_clk();
        BitTick = 1; tick_clk(); BitTick = 0;
        if (t + 1 == reset_ticks) begin
          #2 Reset_n = 0;
          #1 check_outputs_zero("async_reset");
          exp_bits.delete();
          exp_done.delete();
          repeat (3) @(posedge Clock);
          #3 Reset_n = 1;
          tick_clk();
          return;
        end
      end
    end
    waited = 0;
    while (Busy && waited < 10) begin
      tick_clk(); waited++;
    end
    check("busy_drop_timeout", Busy, 0);
    repeat (2) tick_clk();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge Clock);
    #1 check_outputs_zero("reset");
    #2 Reset_n = 1;
    repeat (2) tick_clk();

    mem[0] = 8'hA5; mem[1] = 8'h3C;
    send_packet(2, 0, 0, 0, 8, 8, 0, 0, -1);

    mem[0] = 8'h00;
    send_packet(1, 1, 0, 0, 4, 7, 0, 0, -1);

    for (int i = 0; i < 6; i++) mem[i] = 8'($urandom);
    send_packet(6, 1, 5, 37, 4, 9, 0, 0, -1);

    send_packet(0, 1, 0, 3, 4, 4, 0, 0, -1);

    for (int i = 0; i < 10; i++) mem[i] = 8'($urandom);
    send_packet(10, 1, 2, 17, 4, 6, 0, 0, 27);
    check_outputs_zero("after_reset_release");
    send_packet(4, 1, 1, 11, 4, 6, 0, 0, -1);

    send_packet(3, 0, 0, 0, 5, 8, 0, 1, -1);
    send_packet(2, 1, 0, 25, 4, 8, 1, 0, -1);

    for (int n = 0; n < 12; n++) begin
      int len;
      len = $urandom_range(12, 1);
      for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
      send_packet(len, 1'($urandom), $urandom_range(len + 1, 0), $urandom_range(39, 0),
                  4, 9, 1'($urandom), 1'($urandom), -1);
    end

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    send_packet(255, 1, 100, 39, 4, 4, 0, 0, -1);

    repeat (4) tick_clk();
    check("final_bits_queue", exp_bits.size(), 0);
    check("final_done_queue", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ble_packet_serializer.md
# ble_packet_serializer

Reads a stored BLE packet byte-by-byte from the 256x8 packet RAM (`ble_packet_mem`) and emits it as an LSB-first bit stream, one bit per symbol strobe, to the FSK modulator. It can optionally apply BLE data whitening from a programmable byte offset. It drives the RAM read port (registered output, two-edge read latency) and prefetches the next byte so the bit stream has no gaps between bytes.

## Interface
Parameters
- `MEM_RD_LATENCY`, 2: rising edges from RAM address/ClockEn sample to valid `MemQ`.

Ports (one clock; reset is asynchronous and active-low)
- `Clock`  in  1  system clock.
- `Reset_n`  in  1  asynchronous active-low reset.
- `Start`  in  1  one-cycle request to send a packet; sampled only in IDLE.
- `Length`  in  8  number of bytes to send from address 0; sampled with `Start`.
- `WhitenEn`  in  1  enables whitening; sampled with `Start`.
- `WhitenFrom`  in  8  first byte index that is whitened; sampled with `Start`.
- `Channel`  in  6  BLE channel index used as the LFSR seed; sampled with `Start`.
- `BitTick`  in  1  symbol strobe; spacing at least 4 `Clock` cycles.
- `MemAddress`  out  8  RAM read address.
- `MemClockEn`  out  1  RAM ClockEn/OCE; high for one cycle per read.
- `MemQ`  in  8  RAM read data.
- `BitOut`  out  1  current (whitened) bit.
- `BitValid`  out  1  high while `BitOut` carries a packet bit.
- `Busy`  out  1  high from the cycle after `Start` until `Done`.
- `Done`  out  1  one-cycle pulse after the last bit period ends.

## Operation
- Reset values: all outputs 0, FSM in IDLE, LFSR = 0.
- FSM states:
  - IDLE: `Start` with `Length`=0 → DONE. `Start` with `Length`>0 → FETCH.
  - FETCH: issue a read of address 0, wait `MEM_RD_LATENCY` edges, load the shift register, byte index = 0 → SHIFT.
  - SHIFT: 8 bits per byte. Each `BitTick` advances one bit. After the 8th tick of the last byte → DONE.
  - DONE: pulse `Done` for one cycle → IDLE.
- Prefetch: on each shift-register load, if another byte remains, issue a read of the next address. `MemQ` is captured into a holding register and transferred to the shift register on the byte's 8th `BitTick`.
- Bit order: LSB first. `BitOut = shreg[0] ^ (whiten_active & lfsr[6])`.
- `whiten_active` = `WhitenEn` and byte index ≥ `WhitenFrom`. The LFSR advances only on ticks consumed while whitening is active.
- LFSR: x^7+x^4+1, positions 0..6, output is position 6. On seed, position 0 = 1 and positions 1..6 = `Channel[5:0]` (MSB in position 1). Seeded at `Start`.
- Shift step: out = p6, then p[i] = p[i-1], p0 = out, p4 = p3 ^ out.
- `Start` while `Busy` is ignored. `Length`, `WhitenFrom` and `Channel` changes while `Busy` have no effect.
- Reset asserted mid-packet: outputs go to 0 immediately and the FSM returns to IDLE. There is no resume.
- `MemAddress` holds its last value when `MemClockEn`=0. It never exceeds 254.

## Timing
- Cycle 0: `Start` sampled.
- Cycle 1: `Busy`=1, `MemClockEn`=1, `MemAddress`=0.
- Cycle 3: `MemQ` is valid and loaded into the shift register.
- Cycle 4: `BitValid`=1 and `BitOut` = bit 0 of byte 0.
- `BitOut` changes only in the cycle after a `BitTick`. A `BitTick` before `BitValid` is ignored.
- Byte boundary: the next byte's bit 0 appears in the cycle after the 8th tick (no dead bit).
- After the final tick: the next cycle has `BitValid`=0 and `Done`=1; the following cycle has `Busy`=0.
- `Length`=0: `Done`=1 in cycle 1, `BitValid` stays 0, and no RAM read is issued.
- Throughput: one bit per `BitTick`. Prefetch completes 3 cycles after a load, so a tick spacing of at least 4 cycles is sufficient.

## Structure
- Shared package `ble_tx_pkg`:
  - FSM state enum `ser_state_t` {IDLE, FETCH, SHIFT, DONE}.
  - `BLE_WHITEN_TAP` = 4 and `BLE_WHITEN_LEN` = 7.
  - `MEM_RD_LATENCY` default.
- One sub-module `ble_whiten_lfsr` (seed, advance, out). It is reused later by the CRC/whitening checker.

## Test plan
- `Length`=2, RAM[0]=0xA5, RAM[1]=0x3C, `WhitenEn`=0, ticks every 8 clocks → `BitOut` = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, contiguous. `Done` pulses 1 cycle after the 16th tick.
- `Length`=1, RAM[0]=0x00, `WhitenEn`=1, `WhitenFrom`=0, `Channel`=0 → first 7 bits 0,0,0,0,0,0,1.
- `Length`=6, `WhitenFrom`=5, `Channel`=37 → bytes 0–4 are output unwhitened. Byte 5 is XORed with the LFSR seeded 1,1,0,0,1,0,1 (positions 0..6), so its first bit is inverted.
- `Length`=0 → `Done` in cycle 1, `MemClockEn` never high, `BitValid` never high.
- `Reset_n` asserted mid-byte 3 of a 10-byte packet → all outputs 0 asynchronously. A new `Start` after release restarts from address 0.
- `Start` pulsed while `Busy` with a different `Length` → ignored; the original packet length is sent.
